guess_stream_feeder: RTL and testbench

- Upstream feeder for the backward engine and its forward counterpart.
- Holds the current vector of NUM_UNKNOWNS initial-guess words in Flopoco float format. The trainer writes these through a valid/ready load port.
- On START, streams the words one per cycle onto INPUT_SCALER, in index order, for one pass. An index and a pass-done pulse keep the consumer's address pointers in sync.

---
 rtl/guess_stream_feeder.sv | 157 +++++++++++++++
 tb/tb_guess_stream_feeder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_stream_feeder.sv
// Guess-vector feeder: buffers NUM_UNKNOWNS Flopoco words and streams them in one pass on START.
// Optional macro GUESS_FEED_LOOP_EN: START held through DONE chains passes back to back.
module guess_stream_feeder #(
   parameter int NUM_UNKNOWNS = 2,
   parameter int BIT_WIDTH    = 32,
   parameter int EXTRA_BITS   = 2,
   parameter int IDX_W        = ($clog2(NUM_UNKNOWNS) > 0) ? $clog2(NUM_UNKNOWNS) : 1
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            LOAD_VALID,
   input  logic [BIT_WIDTH+EXTRA_BITS-1:0] LOAD_DATA,
   output logic                            LOAD_READY,
   input  logic                            START,
   input  logic                            ABORT,
   output logic [BIT_WIDTH+EXTRA_BITS-1:0] INPUT_SCALER,
   output logic                            SCALER_VALID,
   output logic [IDX_W-1:0]                SCALER_IDX,
   output logic                            PASS_DONE,
   output logic                            BUSY,
   output logic                            NAN_FLAG
);

   localparam int W = BIT_WIDTH + EXTRA_BITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNKNOWNS - 1);
   localparam logic [IDX_W-1:0] FIRST_FILL_PTR = IDX_W'((NUM_UNKNOWNS == 1) ? 0 : 1);

   typedef enum logic [2:0] {S_IDLE, S_LOADING, S_FULL, S_STREAM, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     guess_buf [NUM_UNKNOWNS];
   logic [IDX_W-1:0] load_ptr_q;
   logic [IDX_W-1:0] stream_ptr_q;
   logic [IDX_W-1:0] stream_nxt;
   logic [IDX_W-1:0] wr_idx;
   logic             load_acc;
   logic             fresh_fill;
   logic             start_pass;
   logic [W-1:0]     scaler_p1;
   logic [IDX_W-1:0] idx_p1;
   logic             vld_p1;
   logic             pass_done_p1;
   logic             nan_q;

   function automatic logic is_nan(input logic [W-1:0] word);
      return word[W-1 -: 2] == 2'b11;
   endfunction

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (load_acc) state_d = (NUM_UNKNOWNS == 1) ? S_FULL : S_LOADING;
         S_LOADING: if (load_acc && load_ptr_q == LAST_IDX) state_d = S_FULL;
         S_FULL: begin
            if (START)         state_d = S_STREAM;
            else if (load_acc) state_d = (NUM_UNKNOWNS == 1) ? S_FULL : S_LOADING;
         end
         S_STREAM: begin
            if (ABORT)                       state_d = S_FULL;
            else if (stream_ptr_q == LAST_IDX) state_d = S_DONE;
         end
         S_DONE: begin
`ifdef GUESS_FEED_LOOP_EN
            state_d = START ? S_STREAM : S_FULL;
`else
            state_d = S_FULL;
`endif
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      LOAD_READY = (state_q == S_IDLE) || (state_q == S_LOADING) || ((state_q == S_FULL) && !START);
      BUSY       = (state_q == S_STREAM);
   end

   // A fill restarts at index 0 whenever the previous vector is absent or being replaced.
   assign load_acc   = LOAD_VALID && LOAD_READY;
   assign fresh_fill = (state_q == S_IDLE) || (state_q == S_FULL);
   assign wr_idx     = fresh_fill ? '0 : load_ptr_q;
   assign start_pass = (state_d == S_STREAM) && (state_q != S_STREAM);
   assign stream_nxt = stream_ptr_q + 1'b1;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NUM_UNKNOWNS; i++) guess_buf[i] <= '0;
      end else if (load_acc) begin
         guess_buf[wr_idx] <= LOAD_DATA;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                 load_ptr_q <= '0;
      else if (load_acc) begin
         if (fresh_fill)          load_ptr_q <= FIRST_FILL_PTR;
         else if (load_ptr_q == LAST_IDX) load_ptr_q <= '0;
         else                     load_ptr_q <= load_ptr_q + 1'b1;
      end
   end

   // Output stage p1: word k is registered on the edge that selects it, so it appears one cycle later.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         scaler_p1    <= '0;
         idx_p1       <= '0;
         vld_p1       <= 1'b0;
         pass_done_p1 <= 1'b0;
         stream_ptr_q <= '0;
      end else begin
         pass_done_p1 <= 1'b0;
         if (start_pass) begin
            vld_p1       <= 1'b1;
            idx_p1       <= '0;
            scaler_p1    <= guess_buf[0];
            stream_ptr_q <= '0;
         end else if (state_q == S_STREAM) begin
            if (ABORT) begin
               vld_p1       <= 1'b0;
               stream_ptr_q <= '0;
            end else if (stream_ptr_q == LAST_IDX) begin
               vld_p1       <= 1'b0;
               pass_done_p1 <= 1'b1;
               stream_ptr_q <= '0;
            end else begin
               vld_p1       <= 1'b1;
               idx_p1       <= stream_nxt;
               scaler_p1    <= guess_buf[stream_nxt];
               stream_ptr_q <= stream_nxt;
            end
         end
      end
   end

   generate
      if (EXTRA_BITS == 2) begin : g_nan
         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET)                            nan_q <= 1'b0;
            else if (load_acc && is_nan(LOAD_DATA)) nan_q <= 1'b1;
         end
      end else begin : g_no_nan
         assign nan_q = 1'b0;
      end
   endgenerate

   assign INPUT_SCALER = scaler_p1;
   assign SCALER_VALID = vld_p1;
   assign SCALER_IDX   = idx_p1;
   assign PASS_DONE    = pass_done_p1;
   assign NAN_FLAG     = nan_q;

endmodule

// File: tb/tb_guess_stream_feeder.sv
// Directed and randomized bench for guess_stream_feeder against a vector-level reference model.
module tb_guess_stream_feeder;

   localparam int N = 2;
   localparam int W = 34;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         LOAD_VALID;
   logic [W-1:0] LOAD_DATA;
   logic         LOAD_READY;
   logic         START;
   logic         ABORT;
   logic [W-1:0] INPUT_SCALER;
   logic         SCALER_VALID;
   logic [0:0]   SCALER_IDX;
   logic         PASS_DONE;
   logic         BUSY;
   logic         NAN_FLAG;

   guess_stream_feeder #(.NUM_UNKNOWNS(N), .BIT_WIDTH(32), .EXTRA_BITS(2)) dut (
      .CLK(CLK), .RESET(RESET), .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA),
      .LOAD_READY(LOAD_READY), .START(START), .ABORT(ABORT), .INPUT_SCALER(INPUT_SCALER),
      .SCALER_VALID(SCALER_VALID), .SCALER_IDX(SCALER_IDX), .PASS_DONE(PASS_DONE),
      .BUSY(BUSY), .NAN_FLAG(NAN_FLAG)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   // Reference model: the stored vector, how many words of the current fill are in, completeness, NaN history.
   logic [W-1:0] mvec [N];
   bit m_full;
   int m_cnt;
   bit m_nan;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [1:0] e;
      e = 2'($urandom_range(0, 3));
      return {e, 32'($urandom)};
   endfunction

   task automatic load_word(input logic [W-1:0] d);
      LOAD_VALID = 1'b1;
      LOAD_DATA  = d;
      #1;
      chk("load_ready_accept", LOAD_READY, 1);
      tick();
      LOAD_VALID = 1'b0;
      if (m_full) begin
         m_full = 1'b0;
         m_cnt  = 0;
      end
      mvec[m_cnt] = d;
      m_cnt++;
      if (m_cnt == N) begin
         m_full = 1'b1;
         m_cnt  = 0;
      end
      if (d[W-1 -: 2] == 2'b11) m_nan = 1'b1;
      chk("nan_flag", NAN_FLAG, m_nan);
   endtask

   // Called one cycle after START was sampled in a full state.
   task automatic stream_check(input int abort_at);
      for (int k = 0; k < N; k++) begin
         chk("stream_valid", SCALER_VALID, 1);
         chk("stream_idx", SCALER_IDX, k);
         chk("stream_data", INPUT_SCALER, mvec[k]);
         chk("stream_ready_low", LOAD_READY, 0);
         chk("stream_busy", BUSY, 1);
         chk("stream_no_done", PASS_DONE, 0);
         if (k == abort_at) begin
            ABORT = 1'b1;
            tick();
            ABORT = 1'b0;
            chk("abort_valid", SCALER_VALID, 0);
            chk("abort_no_done", PASS_DONE, 0);
            chk("abort_busy", BUSY, 0);
            chk("abort_idx_hold", SCALER_IDX, k);
            chk("abort_data_hold", INPUT_SCALER, mvec[k]);
            tick();
            chk("abort_no_done2", PASS_DONE, 0);
            chk("abort_back_full", LOAD_READY, 1);
            return;
         end
         tick();
      end
      chk("done_pulse", PASS_DONE, 1);
      chk("done_valid", SCALER_VALID, 0);
      chk("done_ready_low", LOAD_READY, 0);
      chk("done_idx_hold", SCALER_IDX, N - 1);
      chk("done_data_hold", INPUT_SCALER, mvec[N-1]);
      tick();
      chk("after_done_pulse", PASS_DONE, 0);
      chk("after_done_valid", SCALER_VALID, 0);
      chk("after_done_full", LOAD_READY, 1);
   endtask

   task automatic run_pass(input int abort_at);
      START = 1'b1;
      tick();
      START = 1'b0;
      stream_check(abort_at);
   endtask

   initial begin
      RESET = 1'b0; LOAD_VALID = 1'b0; LOAD_DATA = '0; START = 1'b0; ABORT = 1'b0;
      m_full = 1'b0; m_cnt = 0; m_nan = 1'b0;
      for (int i = 0; i < N; i++) mvec[i] = '0;
      tick();
      tick();
      chk("rst_valid", SCALER_VALID, 0);
      chk("rst_data", INPUT_SCALER, 0);
      chk("rst_idx", SCALER_IDX, 0);
      chk("rst_done", PASS_DONE, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_nan", NAN_FLAG, 0);
      chk("rst_ready", LOAD_READY, 1);
      RESET = 1'b1;
      tick();

      // START in IDLE is ignored.
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("idle_start_valid", SCALER_VALID, 0);
      tick();
      chk("idle_start_valid2", SCALER_VALID, 0);

      // START after a single word (LOADING) is ignored; the fill then completes.
      load_word(34'h1_3F800000);
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("loading_start_valid", SCALER_VALID, 0);
      chk("loading_start_busy", BUSY, 0);
      load_word(34'h1_40000000);
      run_pass(-1);

      // START wins over a simultaneous load in FULL; the old vector streams.
      START = 1'b1;
      LOAD_VALID = 1'b1;
      LOAD_DATA = 34'h0_DEADBEEF;
      #1;
      chk("start_vs_load_ready", LOAD_READY, 0);
      tick();
      START = 1'b0;
      LOAD_VALID = 1'b0;
      stream_check(-1);

      // ABORT on idx0, then a clean pass from idx0.
      run_pass(0);
      run_pass(-1);

      // Randomized vectors, idle gaps and aborts.
      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < N; i++) load_word(rand_word());
         repeat ($urandom_range(0, 2)) tick();
         for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
            if ($urandom_range(0, 3) == 0) run_pass(int'($urandom_range(0, N - 1)));
            else                           run_pass(-1);
         end
      end

      // NaN word sets the sticky flag.
      load_word(34'h3_7FC00000);
      load_word(34'h1_3F800000);
      chk("nan_set", NAN_FLAG, 1);
      run_pass(-1);
      chk("nan_sticky", NAN_FLAG, 1);

      // START held high for three passes.
      START = 1'b1;
      tick();
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < N; k++) begin
            chk("held_valid", SCALER_VALID, 1);
            chk("held_idx", SCALER_IDX, k);
            chk("held_data", INPUT_SCALER, mvec[k]);
            tick();
         end
         chk("held_done", PASS_DONE, 1);
         chk("held_done_valid", SCALER_VALID, 0);
         if (p == 2) START = 1'b0;
         tick();
`ifndef GUESS_FEED_LOOP_EN
         if (p < 2) begin
            chk("held_gap_valid", SCALER_VALID, 0);
            chk("held_gap_done", PASS_DONE, 0);
            tick();
         end
`endif
      end
      chk("held_end_valid", SCALER_VALID, 0);
      chk("held_end_done", PASS_DONE, 0);

      // Reset mid-stream clears everything at once.
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("pre_reset_valid", SCALER_VALID, 1);
      RESET = 1'b0;
      #1;
      chk("mid_rst_valid", SCALER_VALID, 0);
      chk("mid_rst_data", INPUT_SCALER, 0);
      chk("mid_rst_idx", SCALER_IDX, 0);
      chk("mid_rst_done", PASS_DONE, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_nan", NAN_FLAG, 0);
      chk("mid_rst_ready", LOAD_READY, 1);
      tick();
      chk("mid_rst_no_done", PASS_DONE, 0);
      RESET = 1'b1;
      m_full = 1'b0; m_cnt = 0; m_nan = 1'b0;
      for (int i = 0; i < N; i++) mvec[i] = '0;
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("post_rst_start_ignored", SCALER_VALID, 0);
      for (int i = 0; i < N; i++) load_word(rand_word());
      run_pass(-1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
